lcd_hd44780_driver: RTL and testbench

Write-only timing engine for the HD44780-compatible character LCD on the board's I/O bus. It accepts one byte at a time (command or character) over a valid/ready handshake and generates the RS/RW/EN/DATA pin sequence with setup, enable-pulse, hold and execution-wait timing. After reset it runs the power-on initialisation sequence without software involvement. It sits between the load/store unit's LCD register path and the LCD pins, replacing software bit-banging of the LCD control word.

---
 rtl/lcd_hd44780_driver_if.sv | 20 ++
 rtl/lcd_hd44780_driver.sv | 182 ++++++++++++++++++
 tb/tb_lcd_hd44780_driver.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_driver_if.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_driver_if
// Byte-request handshake between the load/store unit's LCD register path
// (master) and the HD44780 timing engine (slave).
//   i_valid : master -> slave, byte request valid (held until accepted)
//   i_rs    : master -> slave, 0 = command, 1 = character data
//   i_data  : master -> slave, byte to write
//   o_ready : slave -> master, high only while the engine is idle
//   o_busy  : slave -> master, always the inverse of o_ready
// ---------------------------------------------------------------------------
interface lcd_hd44780_driver_if;
  logic       i_valid;
  logic       i_rs;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_busy;

  modport master (output i_valid, i_rs, i_data, input  o_ready, o_busy);
  modport slave  (input  i_valid, i_rs, i_data, output o_ready, o_busy);
endinterface

// File: rtl/lcd_hd44780_driver.sv
// ---------------------------------------------------------------------------
// lcd_hd44780_driver
// Write-only timing engine for an HD44780-compatible character LCD. After
// reset it waits POWERON_CYC cycles, then plays a four-byte init sequence.
// Afterwards it accepts one byte per handshake and drives the pins through
// SETUP -> PULSE (EN high) -> HOLD -> EXEC_WAIT before becoming ready again.
//   i_clk      : system clock
//   i_reset    : asynchronous, active-low reset
//   bus        : byte request handshake (slave side)
//   o_lcd_on   : LCD power/backlight enable, set on first edge after reset
//   o_lcd_en   : LCD enable strobe (registered, glitch-free)
//   o_lcd_rs   : LCD register select
//   o_lcd_rw   : LCD read/write, constant 0 (write only)
//   o_lcd_data : LCD data bus
// ---------------------------------------------------------------------------
module lcd_hd44780_driver #(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned PULSE_CYC      = 25,
  parameter int unsigned HOLD_CYC       = 2,
  parameter int unsigned WAIT_CYC       = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 80000,
  parameter int unsigned POWERON_CYC    = 750000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  lcd_hd44780_driver_if.slave  bus,
  output logic                 o_lcd_on,
  output logic                 o_lcd_en,
  output logic                 o_lcd_rs,
  output logic                 o_lcd_rw,
  output logic [7:0]           o_lcd_data
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    SETUP,
    PULSE,
    HOLD,
    EXEC_WAIT,
    IDLE
  } state_t;

  // Each timed state loads (param - 1) on entry and leaves when the counter
  // reads zero, so it lasts exactly param cycles. The power-on wait is loaded
  // directly by reset instead.
  localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
  localparam logic [19:0] PULSE_LD = 20'(PULSE_CYC - 1);
  localparam logic [19:0] HOLD_LD  = 20'(HOLD_CYC - 1);
  localparam logic [19:0] WAIT_LD  = 20'(WAIT_CYC - 1);
  localparam logic [19:0] CLEAR_LD = 20'(CLEAR_WAIT_CYC - 1);
  localparam logic [19:0] PWR_LD   = 20'(POWERON_CYC);

  // Power-on init ROM: 8-bit/2-line, display on, clear, entry increment.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        init_q, init_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        en_q, en_d;
  logic        ready_q, ready_d;
  logic        on_q, on_d;

  logic cnt_zero;
  logic long_wait;

  assign cnt_zero = (cnt_q == 20'd0);
  // Clear Display (0x01) and Return Home (0x02/0x03) need the long wait.
  assign long_wait = !rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'h00);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_zero ? 20'd0 : cnt_q - 20'd1;
    idx_d   = idx_q;
    init_d  = init_q;
    rs_d    = rs_q;
    data_d  = data_q;
    on_d    = 1'b1;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_zero) begin
          rs_d    = 1'b0;
          data_d  = init_byte(2'd0);
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          cnt_d   = PULSE_LD;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          cnt_d   = HOLD_LD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          cnt_d   = long_wait ? CLEAR_LD : WAIT_LD;
          state_d = EXEC_WAIT;
        end
      end
      EXEC_WAIT: begin
        if (cnt_zero) begin
          if (init_q && (idx_q != 2'd3)) begin
            idx_d   = idx_q + 2'd1;
            rs_d    = 1'b0;
            data_d  = init_byte(idx_q + 2'd1);
            cnt_d   = SETUP_LD;
            state_d = SETUP;
          end else begin
            init_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (bus.i_valid) begin
          rs_d    = bus.i_rs;
          data_d  = bus.i_data;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      default: state_d = PWR_WAIT;
    endcase

    // Pin-level outputs are registered from the next state so EN and READY
    // change cleanly on the clock edge with no decode glitches.
    en_d    = (state_d == PULSE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= PWR_WAIT;
      cnt_q   <= PWR_LD;
      idx_q   <= 2'd0;
      init_q  <= 1'b1;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      init_q  <= init_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      on_q    <= on_d;
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_busy  = ~ready_q;
  assign o_lcd_on    = on_q;
  assign o_lcd_en    = en_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
`timescale 1ns/1ps
module tb_lcd_hd44780_driver;

  localparam int S   = 1;
  localparam int P   = 3;
  localparam int H   = 1;
  localparam int W   = 5;
  localparam int CW  = 20;
  localparam int PON = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  lcd_hd44780_driver_if bus ();

  lcd_hd44780_driver #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .WAIT_CYC(W),
    .CLEAR_WAIT_CYC(CW), .POWERON_CYC(PON)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .bus(bus),
    .o_lcd_on(lcd_on), .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs),
    .o_lcd_rw(lcd_rw), .o_lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  // Rising-edge counter; read at negedges it names the most recent edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " en"},    32'(lcd_en), 0);
    check({tag, " rs"},    32'(lcd_rs), 0);
    check({tag, " rw"},    32'(lcd_rw), 0);
    check({tag, " data"},  32'(lcd_data), 0);
    check({tag, " on"},    32'(lcd_on), 0);
    check({tag, " ready"}, 32'(bus.o_ready), 0);
    check({tag, " busy"},  32'(bus.o_busy), 1);
  endtask

  // Releases reset and checks the full power-on init sequence timing.
  task automatic run_init(input string tag);
    int rel, n, rdy;
    int rise[4];
    logic [7:0] rdat[4];
    logic rrs[4];
    logic prev, done;
    logic [7:0] exp_dat[4];
    exp_dat[0] = 8'h38; exp_dat[1] = 8'h0C; exp_dat[2] = 8'h01; exp_dat[3] = 8'h06;
    n = 0; rdy = 0; prev = 1'b0; done = 1'b0;
    for (int i = 0; i < 4; i++) begin rise[i] = 0; rdat[i] = 8'h00; rrs[i] = 1'b1; end
    @(negedge clk);
    check_reset_outputs({tag, " in reset"});
    rst_n = 1'b1;
    rel = cyc;
    @(negedge clk);
    check({tag, " lcd_on after release"}, 32'(lcd_on), 1);
    for (int i = 0; i < 400 && !done; i++) begin
      if (lcd_en && !prev) begin
        if (n < 4) begin rise[n] = cyc; rdat[n] = lcd_data; rrs[n] = lcd_rs; end
        n++;
      end
      prev = lcd_en;
      if (bus.o_ready) begin rdy = cyc; done = 1'b1; end
      else @(negedge clk);
    end
    check({tag, " init ready seen"}, 32'(done), 1);
    check({tag, " init pulse count"}, n, 4);
    check({tag, " first EN rise"}, rise[0] - rel, PON + S + 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s init data %0d", tag, i), 32'(rdat[i]), 32'(exp_dat[i]));
      check($sformatf("%s init rs %0d", tag, i), 32'(rrs[i]), 0);
    end
    check({tag, " gap 0x38"}, rise[1] - rise[0], P + H + W + S);
    check({tag, " gap 0x0C"}, rise[2] - rise[1], P + H + W + S);
    check({tag, " gap 0x01"}, rise[3] - rise[2], P + H + CW + S);
    check({tag, " ready after 0x06"}, rdy - rise[3], P + H + W);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 300 && !bus.o_ready; i++) @(negedge clk);
    check({tag, " ready wait"}, 32'(bus.o_ready), 1);
  endtask

  // One handshake transfer; reports edge numbers relative to the accept edge.
  task automatic xfer(input logic r, input logic [7:0] d, output int acc, output int rise,
                      output int hi, output logic [7:0] sdat, output logic srs,
                      output int rdy, output int nrise);
    logic prev;
    acc = 0; rise = 0; hi = 0; sdat = 8'h00; srs = 1'b0; rdy = 0; nrise = 0; prev = 1'b0;
    wait_ready("xfer");
    bus.i_valid = 1'b1; bus.i_rs = r; bus.i_data = d;
    @(negedge clk);
    acc = cyc;
    // Garbage on rs/data after acceptance must be ignored.
    bus.i_valid = 1'b0; bus.i_rs = ~r; bus.i_data = 8'hFF;
    check("busy after accept", 32'(bus.o_busy), 1);
    for (int i = 0; i < 300; i++) begin
      if (lcd_en && !prev) begin nrise++; rise = cyc; sdat = lcd_data; srs = lcd_rs; end
      if (lcd_en) hi++;
      prev = lcd_en;
      if (bus.o_ready) begin rdy = cyc; break; end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wait_cyc;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rise, hi, rdy, nrise, n2, nacc, r0, r1;
    logic [7:0] sdat, d0, d1;
    logic srs, prev, saw55, pending;

    vecs[0] = '{1'b1, 8'h41, W};
    vecs[1] = '{1'b0, 8'h01, CW};
    vecs[2] = '{1'b0, 8'h02, CW};
    vecs[3] = '{1'b0, 8'h03, CW};
    vecs[4] = '{1'b0, 8'h00, W};
    vecs[5] = '{1'b0, 8'h80, W};
    vecs[6] = '{1'b1, 8'h01, W};
    vecs[7] = '{1'b0, 8'h04, W};

    bus.i_valid = 1'b0; bus.i_rs = 1'b0; bus.i_data = 8'h00;
    repeat (3) @(negedge clk);
    run_init("por");

    // Table-driven single transfers.
    for (int v = 0; v < 8; v++) begin
      xfer(vecs[v].rs, vecs[v].data, acc, rise, hi, sdat, srs, rdy, nrise);
      check($sformatf("vec%0d pulse count", v), nrise, 1);
      check($sformatf("vec%0d data", v), 32'(sdat), 32'(vecs[v].data));
      check($sformatf("vec%0d rs", v), 32'(srs), 32'(vecs[v].rs));
      check($sformatf("vec%0d en rise delay", v), rise - acc, S);
      check($sformatf("vec%0d en width", v), hi, P);
      check($sformatf("vec%0d ready delay", v), rdy - acc, S + P + H + vecs[v].wait_cyc);
    end

    // Request pulsed while busy is dropped.
    wait_ready("drop");
    bus.i_valid = 1'b1; bus.i_rs = 1'b1; bus.i_data = 8'h30;
    @(negedge clk);
    bus.i_data = 8'h55;
    n2 = 0; prev = 1'b0; saw55 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (lcd_en && !prev) n2++;
      prev = lcd_en;
      if (lcd_data == 8'h55) saw55 = 1'b1;
      if (i == 1) bus.i_valid = 1'b0;
      if (bus.o_ready && i > 1) break;
      @(negedge clk);
    end
    repeat (6) begin
      @(negedge clk);
      if (lcd_en && !prev) n2++;
      prev = lcd_en;
      if (lcd_data == 8'h55) saw55 = 1'b1;
    end
    check("drop pulse count", n2, 1);
    check("drop data never 0x55", 32'(saw55), 0);
    check("drop still idle", 32'(bus.o_ready), 1);

    // Back-to-back with i_valid held: 0x48 then 0x49.
    wait_ready("b2b");
    bus.i_valid = 1'b1; bus.i_rs = 1'b1; bus.i_data = 8'h48;
    nacc = 0; pending = 1'b0; n2 = 0; prev = 1'b0; r0 = 0; r1 = 0; d0 = 8'h00; d1 = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (pending) begin
        nacc++;
        pending = 1'b0;
        if (nacc == 1) bus.i_data = 8'h49;
        else bus.i_valid = 1'b0;
      end
      if (lcd_en && !prev) begin
        if (n2 == 0) begin r0 = cyc; d0 = lcd_data; end
        else if (n2 == 1) begin r1 = cyc; d1 = lcd_data; end
        n2++;
      end
      prev = lcd_en;
      if (bus.o_ready && bus.i_valid) pending = 1'b1;
      if (bus.o_ready && !bus.i_valid) break;
      @(negedge clk);
    end
    check("b2b accept count", nacc, 2);
    check("b2b pulse count", n2, 2);
    check("b2b first data", 32'(d0), 32'h48);
    check("b2b second data", 32'(d1), 32'h49);
    check("b2b en rise spacing", r1 - r0, P + H + W + 1 + S);

    // Reset asserted while EN is high.
    wait_ready("rst");
    bus.i_valid = 1'b1; bus.i_rs = 1'b1; bus.i_data = 8'h5A;
    @(negedge clk);
    bus.i_valid = 1'b0;
    for (int i = 0; i < 20 && !lcd_en; i++) @(negedge clk);
    check("rst en high before reset", 32'(lcd_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-pulse reset");
    run_init("re-init");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
